// File: rtl/ctrl_decode_stage.sv
// Registered ARM-subset decode stage: one instruction per handshake into a held control bundle.
// Owns the NZCV register, resolves B.cond with EX flag forwarding, and stalls on flag hazards.
module ctrl_decode_stage #(
   parameter int ALUOP_W   = 3,
   parameter int PEND_W    = 2,
   parameter int CNT_W     = 8,
   parameter bit FULL_COND = 1'b1,
   parameter bit EXT_OPS   = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic               cb_zero,
   input  logic               ex_flag_we,
   input  logic [3:0]         ex_flags,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               reg2loc,
   output logic               uncond_br,
   output logic               br_taken,
   output logic               reg_write,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               flag_write,
   output logic [1:0]         alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal,
   output logic [CNT_W-1:0]   illegal_cnt,
   output logic [3:0]         flags
);

   localparam logic [ALUOP_W-1:0] OP_PASS = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] OP_LSL  = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(3'b100);
   localparam logic [ALUOP_W-1:0] OP_LSR  = ALUOP_W'(3'b101);
   localparam logic [ALUOP_W-1:0] OP_EOR  = ALUOP_W'(3'b110);
   localparam logic [PEND_W-1:0]  PEND_MAX = {PEND_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

   // flags layout: [3]=N [2]=Z [1]=C [0]=V; codes 111x are always-taken
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic base;
      case (c[3:1])
         3'b000:  base = f[2];
         3'b001:  base = f[1];
         3'b010:  base = f[3];
         3'b011:  base = f[0];
         3'b100:  base = f[1] & !f[2];
         3'b101:  base = (f[3] == f[0]);
         3'b110:  base = !f[2] & (f[3] == f[0]);
         default: base = 1'b1;
      endcase
      return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
   endfunction

   logic [10:0]        opc;
   logic [3:0]         cur_flags;
   logic               d_reg2loc, d_uncond_br, d_br_taken, d_reg_write, d_mem_write;
   logic               d_mem_to_reg, d_flag_write, d_illegal, is_bcond, is_fset;
   logic [1:0]         d_alu_src;
   logic [ALUOP_W-1:0] d_alu_op;
   logic [PEND_W-1:0]  pend_cnt, pend_next;
   logic [PEND_W:0]    pend_up;
   logic [1:0]         pend_dn;
   logic               hazard, capture;

   assign opc       = instr[31:21];
   assign cur_flags = ex_flag_we ? ex_flags : flags;

   always_comb begin
      d_reg2loc    = 1'b0;
      d_uncond_br  = 1'b0;
      d_br_taken   = 1'b0;
      d_reg_write  = 1'b0;
      d_mem_write  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_flag_write = 1'b0;
      d_illegal    = 1'b0;
      d_alu_src    = 2'b00;
      d_alu_op     = OP_PASS;
      is_bcond     = 1'b0;
      is_fset      = 1'b0;
      casez (opc)
         11'b10101011000: begin d_reg_write = 1'b1; d_flag_write = 1'b1; is_fset = 1'b1; d_alu_op = OP_ADD; end
         11'b11101011000: begin d_reg_write = 1'b1; d_flag_write = 1'b1; is_fset = 1'b1; d_alu_op = OP_SUB; end
         11'b1001000100?: begin d_reg_write = 1'b1; d_alu_src = 2'b10; d_alu_op = OP_ADD; end
         11'b10001010000: begin d_reg_write = 1'b1; d_alu_op = OP_AND; end
         11'b11001010000: begin d_reg_write = 1'b1; d_alu_op = OP_EOR; end
         11'b11111000010: begin d_reg_write = 1'b1; d_mem_to_reg = 1'b1; d_alu_src = 2'b01; d_alu_op = OP_ADD; end
         11'b11111000000: begin d_reg2loc = 1'b1; d_mem_write = 1'b1; d_alu_src = 2'b01; d_alu_op = OP_ADD; end
         11'b000101?????: begin d_uncond_br = 1'b1; d_br_taken = 1'b1; end
         11'b10110100???: begin d_reg2loc = 1'b1; d_br_taken = cb_zero; end
         11'b01010100???: begin
            is_bcond   = 1'b1;
            d_br_taken = FULL_COND ? cond_true(instr[3:0], cur_flags) : (cur_flags[3] != cur_flags[0]);
         end
         11'b11010011010: begin d_reg_write = 1'b1; d_alu_src = 2'b11; d_alu_op = OP_LSR; end
         11'b11010011011: begin
            if (EXT_OPS) begin d_reg_write = 1'b1; d_alu_src = 2'b11; d_alu_op = OP_LSL; end
            else d_illegal = 1'b1;
         end
         11'b10110101???: begin
            if (EXT_OPS) begin d_reg2loc = 1'b1; d_br_taken = !cb_zero; end
            else d_illegal = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
   end

   assign hazard   = (is_bcond & !((pend_cnt == '0) | ((pend_cnt == PEND_W'(1)) & ex_flag_we)))
                   | (is_fset & (pend_cnt == PEND_MAX));
   assign in_ready = (!out_valid | out_ready) & !flush & !hazard;
   assign capture  = in_valid & in_ready;

   // a flushed flag-setter never retires, so its pending slot is released here
   assign pend_up = {1'b0, pend_cnt} + (PEND_W+1)'(capture & is_fset);
   assign pend_dn = {1'b0, ex_flag_we} + {1'b0, flush & out_valid & flag_write};
   always_comb begin
      pend_next = '0;
      if (pend_up >= (PEND_W+1)'(pend_dn))
         pend_next = PEND_W'(pend_up - (PEND_W+1)'(pend_dn));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         reg2loc     <= 1'b0;
         uncond_br   <= 1'b0;
         br_taken    <= 1'b0;
         reg_write   <= 1'b0;
         mem_write   <= 1'b0;
         mem_to_reg  <= 1'b0;
         flag_write  <= 1'b0;
         alu_src     <= 2'b00;
         alu_op      <= '0;
         illegal     <= 1'b0;
         illegal_cnt <= '0;
         flags       <= 4'b0000;
         pend_cnt    <= '0;
      end else begin
         if (ex_flag_we)
            flags <= ex_flags;
         pend_cnt <= pend_next;
         if (capture) begin
            out_valid  <= 1'b1;
            reg2loc    <= d_reg2loc;
            uncond_br  <= d_uncond_br;
            br_taken   <= d_br_taken;
            reg_write  <= d_reg_write;
            mem_write  <= d_mem_write;
            mem_to_reg <= d_mem_to_reg;
            flag_write <= d_flag_write;
            alu_src    <= d_alu_src;
            alu_op     <= d_alu_op;
            illegal    <= d_illegal;
            if (d_illegal && (illegal_cnt != CNT_MAX))
               illegal_cnt <= illegal_cnt + 1'b1;
         end else if (flush || out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: hand-computed control bundles, flag hazards,
// forwarding, back-pressure, flush, illegal counting and reset.
module tb_ctrl_decode_stage;

   logic        clk = 1'b0;
   logic        reset_n, in_valid, cb_zero, ex_flag_we, flush, out_ready;
   logic [31:0] instr;
   logic [3:0]  ex_flags;

   logic       in_ready, out_valid, reg2loc, uncond_br, br_taken, reg_write, mem_write;
   logic       mem_to_reg, flag_write, illegal;
   logic [1:0] alu_src;
   logic [2:0] alu_op;
   logic [7:0] illegal_cnt;
   logic [3:0] flags;

   logic       b_in_ready, b_out_valid, b_reg2loc, b_uncond_br, b_br_taken, b_reg_write, b_mem_write;
   logic       b_mem_to_reg, b_flag_write, b_illegal;
   logic [1:0] b_alu_src;
   logic [2:0] b_alu_op;
   logic [7:0] b_illegal_cnt;
   logic [3:0] b_flags;

   int n_asserts = 0;
   int n_fail    = 0;

   localparam logic [31:0] I_SUBS = {11'b11101011000, 21'd0};
   localparam logic [31:0] I_ADDS = {11'b10101011000, 21'd0};
   localparam logic [31:0] I_ADDI = {11'b10010001000, 21'd0};
   localparam logic [31:0] I_EOR  = {11'b11001010000, 21'd0};
   localparam logic [31:0] I_BLT  = {11'b01010100000, 17'd0, 4'b1011};
   localparam logic [31:0] I_BEQ  = {11'b01010100000, 17'd0, 4'b0000};
   localparam logic [31:0] I_BGT  = {11'b01010100000, 17'd0, 4'b1100};
   localparam logic [31:0] I_CBZ  = {11'b10110100000, 21'd0};
   localparam logic [31:0] I_CBNZ = {11'b10110101000, 21'd0};
   localparam logic [31:0] I_B    = {6'b000101, 26'd5};
   localparam logic [31:0] I_LDUR = {11'b11111000010, 21'd0};
   localparam logic [31:0] I_STUR = {11'b11111000000, 21'd0};
   localparam logic [31:0] I_LSL  = {11'b11010011011, 21'd0};

   always #5 clk = ~clk;

   ctrl_decode_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .cb_zero(cb_zero), .ex_flag_we(ex_flag_we), .ex_flags(ex_flags), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .reg2loc(reg2loc), .uncond_br(uncond_br),
      .br_taken(br_taken), .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .flag_write(flag_write), .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
      .illegal_cnt(illegal_cnt), .flags(flags)
   );

   ctrl_decode_stage #(.FULL_COND(1'b0), .EXT_OPS(1'b0)) dut_legacy (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
      .cb_zero(cb_zero), .ex_flag_we(ex_flag_we), .ex_flags(ex_flags), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .reg2loc(b_reg2loc), .uncond_br(b_uncond_br),
      .br_taken(b_br_taken), .reg_write(b_reg_write), .mem_write(b_mem_write),
      .mem_to_reg(b_mem_to_reg), .flag_write(b_flag_write), .alu_src(b_alu_src), .alu_op(b_alu_op),
      .illegal(b_illegal), .illegal_cnt(b_illegal_cnt), .flags(b_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; instr = 32'd0; cb_zero = 1'b0;
      ex_flag_we = 1'b0; ex_flags = 4'd0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", flags, 0);
      check("rst_illegal_cnt", illegal_cnt, 0);
      check("rst_illegal", illegal, 0);
      check("rst_reg_write", reg_write, 0);
      check("rst_alu_op", alu_op, 0);
      reset_n = 1'b1;

      // SUBS then B.LT stalls until EX retires the flags
      in_valid = 1'b1; instr = I_SUBS; #1;
      check("subs_in_ready", in_ready, 1);
      tick();
      check("subs_out_valid", out_valid, 1);
      check("subs_flag_write", flag_write, 1);
      check("subs_alu_op", alu_op, 3'b011);
      instr = I_BLT; #1;
      check("blt_stall", in_ready, 0);
      tick();
      check("blt_drained", out_valid, 0);
      ex_flag_we = 1'b1; ex_flags = 4'b1000; #1;
      check("blt_fwd_ready", in_ready, 1);
      tick();
      check("blt_out_valid", out_valid, 1);
      check("blt_taken", br_taken, 1);
      check("blt_flags", flags, 4'b1000);
      ex_flag_we = 1'b0;

      // ADDS, then B.EQ arriving with the retiring flags
      instr = I_ADDS; tick();
      check("adds_flag_write", flag_write, 1);
      instr = I_BEQ; ex_flag_we = 1'b1; ex_flags = 4'b0100; #1;
      check("beq_no_stall", in_ready, 1);
      tick();
      check("beq_taken", br_taken, 1);
      check("beq_flags", flags, 4'b0100);
      check("beq_alu_op", alu_op, 3'b000);
      ex_flag_we = 1'b0;

      // back-pressure on a held ADDI
      instr = I_ADDI; tick();
      check("addi_alu_src", alu_src, 2'b10);
      check("addi_alu_op", alu_op, 3'b010);
      out_ready = 1'b0; instr = I_EOR;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_alu_src", alu_src, 2'b10);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1; #1;
      check("release_in_ready", in_ready, 1);
      tick();
      check("eor_alu_op", alu_op, 3'b110);
      check("eor_alu_src", alu_src, 2'b00);

      // flush of a held SUBS releases its pending flag slot
      instr = I_SUBS; tick();
      check("subs2_valid", out_valid, 1);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
      tick();
      check("flush_out_valid", out_valid, 0);
      flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; instr = I_BGT; #1;
      check("post_flush_ready", in_ready, 1);
      tick();
      check("bgt_valid", out_valid, 1);
      check("bgt_not_taken", br_taken, 0);

      // remaining opcode classes
      instr = I_CBZ; cb_zero = 1'b1; tick();
      check("cbz_taken", br_taken, 1);
      check("cbz_reg2loc", reg2loc, 1);
      instr = I_CBNZ; tick();
      check("cbnz_not_taken", br_taken, 0);
      check("cbnz_legal", illegal, 0);
      check("cbnz_legacy_illegal", b_illegal, 1);
      check("cbnz_legacy_br", b_br_taken, 0);
      cb_zero = 1'b0;
      instr = I_B; tick();
      check("b_uncond", uncond_br, 1);
      check("b_taken", br_taken, 1);
      instr = I_LDUR; tick();
      check("ldur_mem_to_reg", mem_to_reg, 1);
      check("ldur_alu_src", alu_src, 2'b01);
      instr = I_STUR; tick();
      check("stur_mem_write", mem_write, 1);
      check("stur_reg_write", reg_write, 0);
      instr = I_LSL; tick();
      check("lsl_alu_op", alu_op, 3'b001);
      check("lsl_alu_src", alu_src, 2'b11);

      // illegal opcode counter saturation
      instr = 32'd0;
      for (int k = 1; k <= 260; k++) begin
         tick();
         check("ill_flag", illegal, 1);
         check("ill_reg_write", reg_write, 0);
         check("ill_cnt", illegal_cnt, (k > 255) ? 255 : k);
      end

      // reset in the middle of a stall with two flag writers pending
      instr = I_SUBS; tick();
      instr = I_ADDS; tick();
      instr = I_BLT; #1;
      check("pend2_stall", in_ready, 0);
      reset_n = 1'b0; ex_flag_we = 1'b1; ex_flags = 4'hf;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_flags", flags, 0);
      check("mid_rst_cnt", illegal_cnt, 0);
      reset_n = 1'b1; ex_flag_we = 1'b0; #1;
      check("post_rst_ready", in_ready, 1);
      tick();
      check("post_rst_valid", out_valid, 1);
      check("post_rst_blt", br_taken, 0);

      // legacy condition handling ignores the condition code
      instr = I_BEQ; ex_flag_we = 1'b1; ex_flags = 4'b1000;
      tick();
      check("full_beq", br_taken, 0);
      check("legacy_beq", b_br_taken, 1);
      ex_flag_we = 1'b0; in_valid = 1'b0;
      tick();
      check("idle_drain", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
